ad2_i2c_responder: RTL and testbench
====================================

Name: ad2_i2c_responder

Overview:
I2C target that emulates the PmodAD2 (AD7991) ADC on the bus driven by the board's I2C master controller. It decodes the 7-bit device address, accepts configuration-byte writes, and returns 12-bit samples, tagged with their channel ID, in the AD7991 two-byte read format. It is used in loopback and bench setups, and on a second board as a stand-in ADC. Sample values come from four parallel 12-bit inputs.

Parameters:
DEV_ADDR, 7'h28, 7-bit I2C address answered
SYNC_STAGES, 2, synchroniser depth on scl_in/sda_in (min 2)
CFG_RESET, 8'h10, configuration register value after reset (CH0 only)

Ports:
clk  in  1  system clock (100 MHz); SCL assumed <= clk/20
rst  in  1  reset, asynchronous, active-high
scl_in  in  1  SCL pad input (target never stretches clock)
sda_in  in  1  SDA pad input
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
ch0_data..ch3_data  in  12 each  sample source per channel
cfg  out  8  current configuration byte; [7:4] = CH3..CH0 select
cfg_wr  out  1  one-clk pulse when a config byte is accepted
rd_ch  out  2  channel ID of the sample most recently latched
rd_strobe  out  1  one-clk pulse when a sample is latched for transmission
busy  out  1  high from addressed START until STOP/NACK release

Behaviour:
- Reset (async): sda_oe=0, cfg=CFG_RESET, cfg_wr=0, rd_ch=0, rd_strobe=0, busy=0, FSM=IDLE, channel pointer = lowest selected channel. sda_oe releases immediately on reset assertion, including mid-transaction.
- Inputs pass through SYNC_STAGES flops, then 1 flop for edge detection. All decisions use the synchronised values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognised in every state. START -> ADDR (repeated start allowed). STOP -> IDLE, sda_oe=0, busy=0.
- Data is sampled on SCL rising edges. sda_oe changes only on SCL falling edges, 1 clk after detection.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- ADDR: shift 8 bits MSB first.
  - Address match: ADDR_ACK, drive ACK for the 9th bit, busy=1.
  - Mismatch: WAIT_STOP, SDA never driven.
- After ADDR_ACK: R/W=0 -> WR_BYTE; R/W=1 -> RD_BYTE, high byte first.
- WR_BYTE: after 8 bits, cfg takes the received byte and cfg_wr pulses in the same clk. The byte is ACKed, then the FSM returns to WR_BYTE. Multiple bytes are allowed; the last one wins. Any write of cfg resets the channel pointer to the lowest selected channel.
- Channel pointer: if cfg[7:4]==0, CH0 is treated as selected.
- RD_BYTE, high byte:
  - At the falling edge that starts the byte, snapshot the pointed channel's data and pulse rd_strobe; rd_ch takes the pointer value.
  - Transmit {2'b00, ch_id[1:0], data[11:8]}.
  - The low byte transmits data[7:0] from the same snapshot (no tearing).
- Transmission: sda_oe = ~bit. sda_oe is released for the master's ACK slot.
- RD_ACK: master ACK (SDA low) -> next byte. After a low byte, first advance the pointer to the next selected channel in ascending order, wrapping to the lowest. Master NACK -> WAIT_STOP, SDA released.
- WAIT_STOP: ignore bits until STOP or START.
- START/STOP during a byte aborts it. A partial write byte does not update cfg.

Decomposition:
- Package ad2_i2c_pkg: FSM state enum, AD7991 default address constant, read-byte field positions (CH_ID at [5:4]), CFG_RESET default.
- Sub-module i2c_bus_sync: synchroniser, edge detection, start/stop detection. Outputs are scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- Write 0x28+W, data 0x30 -> ACK on both bytes; cfg=0x30, one cfg_wr pulse, pointer=CH0.
- cfg=0x30, ch0=0xABC, ch1=0x123; read 6 bytes, master ACKing all but the last:
  - Bytes returned: 0x0A 0xBC 0x11 0x23 0x0A 0xBC.
  - rd_strobe pulses 3 times, rd_ch sequence 0,1,0.
  - SDA released after the final NACK.
- Address 0x29 -> no ACK (sda_oe stays 0 for the entire frame), cfg unchanged, busy=0; the following STOP then a valid START works normally.
- Repeated START after 4 bits of a write byte -> cfg unchanged, address phase restarts and ACKs.
- Assert rst while the target is driving a 0 data bit -> sda_oe=0 within the same clk, cfg=0x10.
- ch0_data changes between the high and low bytes -> low byte carries the snapshot value, not the new one.

Source files
------------

// File: rtl/ad2_i2c_pkg.sv
// ad2_i2c_pkg
// Shared definitions for the PmodAD2 (AD7991) I2C target emulation:
// FSM state encoding, default device address and configuration value,
// read-byte field positions, and channel-pointer helper functions.
package ad2_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_e;

    localparam logic [6:0] AD7991_ADDR   = 7'h28;
    localparam logic [7:0] CFG_RESET_DEF = 8'h10;

    // High read byte layout: {2'b00, ch_id[1:0], data[11:8]}
    localparam int CH_ID_LSB = 4;
    localparam int CH_ID_MSB = 5;

    // Channel select mask from cfg[7:4]; an empty mask falls back to CH0.
    function automatic logic [3:0] chan_sel(input logic [7:0] cfg_val);
        return (cfg_val[7:4] == 4'b0000) ? 4'b0001 : cfg_val[7:4];
    endfunction

    function automatic logic [1:0] lowest_chan(input logic [7:0] cfg_val);
        logic [3:0] sel;
        logic [1:0] res;
        sel = chan_sel(cfg_val);
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i]) res = 2'(i);
        end
        return res;
    endfunction

    // Next selected channel above ptr, wrapping; stays on ptr if it is alone.
    function automatic logic [1:0] next_chan(input logic [7:0] cfg_val,
                                             input logic [1:0] ptr);
        logic [3:0] sel;
        logic [1:0] res;
        logic [1:0] idx;
        sel = chan_sel(cfg_val);
        res = ptr;
        // Descending scan so the nearest candidate is the last one written.
        for (int k = 3; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (sel[idx]) res = idx;
        end
        return res;
    endfunction

    function automatic logic [7:0] hi_byte(input logic [1:0] ch_id,
                                           input logic [11:0] data);
        logic [7:0] b;
        b = 8'h00;
        b[CH_ID_MSB:CH_ID_LSB] = ch_id;
        b[3:0] = data[11:8];
        return b;
    endfunction

endpackage

// File: rtl/ad2_i2c_responder_sync.sv
// i2c_bus_sync
// Synchronises SCL/SDA into clk, then keeps one extra flop of history
// for edge detection. Emits single-cycle SCL rise/fall, START and STOP.
//   clk, rst        : system clock, async active-high reset
//   scl_in, sda_in  : raw pad inputs
//   scl_rise/fall   : synchronised SCL edges
//   start_det       : SDA fell while SCL high
//   stop_det        : SDA rose while SCL high
//   sda_s           : synchronised SDA level
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;

    // Reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/ad2_i2c_responder.sv
// ad2_i2c_responder
// I2C target emulating the AD7991 ADC on a PmodAD2. Accepts configuration
// byte writes and returns channel-tagged 12-bit samples as two bytes.
//   clk, rst            : system clock, async active-high reset
//   scl_in, sda_in      : I2C pad inputs
//   sda_oe              : 1 pulls SDA low (open-drain)
//   ch0..ch3_data       : 12-bit sample sources
//   cfg, cfg_wr         : configuration byte and its write pulse
//   rd_ch, rd_strobe    : channel of latched sample and latch pulse
//   busy                : addressed transaction in progress
module ad2_i2c_responder
    import ad2_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = AD7991_ADDR,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CFG_RESET   = CFG_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [11:0] ch0_data,
    input  logic [11:0] ch1_data,
    input  logic [11:0] ch2_data,
    input  logic [11:0] ch3_data,
    output logic [7:0]  cfg,
    output logic        cfg_wr,
    output logic [1:0]  rd_ch,
    output logic        rd_strobe,
    output logic        busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    state_e      state_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  tx_q;
    logic [11:0] snap_q;
    logic [1:0]  ptr_q;
    logic        rw_q;
    logic        phase_q;    // ACK states: first half of the ACK bit done
    logic        byte_lo_q;  // current read byte is the low byte
    logic        mack_q;     // master acknowledged the last read byte
    logic        sda_oe_q;
    logic [7:0]  cfg_q;
    logic        cfg_wr_q;
    logic [1:0]  rd_ch_q;
    logic        rd_strobe_q;
    logic        busy_q;

    logic [7:0]  rx_byte_d;
    logic [1:0]  load_ptr_d;
    logic [11:0] load_data_d;
    logic [7:0]  load_hi_d;

    assign rx_byte_d = {shift_q[6:0], sda_s};

    // A high byte is loaded either right after the address ACK (current
    // pointer) or after an ACKed low byte (pointer advanced first).
    always_comb begin
        load_ptr_d  = (state_q == ST_RD_ACK) ? next_chan(cfg_q, ptr_q) : ptr_q;
        load_data_d = ch0_data;
        case (load_ptr_d)
            2'd0:    load_data_d = ch0_data;
            2'd1:    load_data_d = ch1_data;
            2'd2:    load_data_d = ch2_data;
            default: load_data_d = ch3_data;
        endcase
        load_hi_d = hi_byte(load_ptr_d, load_data_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            snap_q      <= 12'h000;
            ptr_q       <= lowest_chan(CFG_RESET);
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            byte_lo_q   <= 1'b0;
            mack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            cfg_q       <= CFG_RESET;
            cfg_wr_q    <= 1'b0;
            rd_ch_q     <= 2'd0;
            rd_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cfg_wr_q    <= 1'b0;
            rd_strobe_q <= 1'b0;
            if (stop_det) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (start_det) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte_d;
                            if (bit_cnt_q == 4'd7) begin
                                if (rx_byte_d[7:1] == DEV_ADDR) begin
                                    state_q <= ST_ADDR_ACK;
                                    rw_q    <= rx_byte_d[0];
                                    phase_q <= 1'b0;
                                    busy_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_WAIT_STOP;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else if (rw_q) begin
                                state_q     <= ST_RD_BYTE;
                                snap_q      <= load_data_d;
                                tx_q        <= load_hi_d;
                                sda_oe_q    <= ~load_hi_d[7];
                                rd_strobe_q <= 1'b1;
                                rd_ch_q     <= load_ptr_d;
                                ptr_q       <= load_ptr_d;
                                bit_cnt_q   <= 4'd0;
                                byte_lo_q   <= 1'b0;
                            end else begin
                                state_q   <= ST_WR_BYTE;
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 4'd0;
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte_d;
                            if (bit_cnt_q == 4'd7) begin
                                cfg_q    <= rx_byte_d;
                                cfg_wr_q <= 1'b1;
                                ptr_q    <= lowest_chan(rx_byte_d);
                                state_q  <= ST_WR_ACK;
                                phase_q  <= 1'b0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else begin
                                state_q   <= ST_WR_BYTE;
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 4'd0;
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                // Release for the master's ACK slot.
                                state_q  <= ST_RD_ACK;
                                sda_oe_q <= 1'b0;
                                phase_q  <= 1'b0;
                            end else begin
                                tx_q     <= {tx_q[6:0], 1'b0};
                                sda_oe_q <= ~tx_q[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            mack_q  <= ~sda_s;
                            phase_q <= 1'b1;
                        end else if (scl_fall && phase_q) begin
                            if (!mack_q) begin
                                state_q  <= ST_WAIT_STOP;
                                sda_oe_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end else if (!byte_lo_q) begin
                                // Low byte comes from the snapshot taken with
                                // the high byte, so the pair never tears.
                                state_q   <= ST_RD_BYTE;
                                tx_q      <= snap_q[7:0];
                                sda_oe_q  <= ~snap_q[7];
                                bit_cnt_q <= 4'd0;
                                byte_lo_q <= 1'b1;
                            end else begin
                                state_q     <= ST_RD_BYTE;
                                snap_q      <= load_data_d;
                                tx_q        <= load_hi_d;
                                sda_oe_q    <= ~load_hi_d[7];
                                rd_strobe_q <= 1'b1;
                                rd_ch_q     <= load_ptr_d;
                                ptr_q       <= load_ptr_d;
                                bit_cnt_q   <= 4'd0;
                                byte_lo_q   <= 1'b0;
                            end
                        end
                    end
                    ST_WAIT_STOP: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign cfg       = cfg_q;
    assign cfg_wr    = cfg_wr_q;
    assign rd_ch     = rd_ch_q;
    assign rd_strobe = rd_strobe_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ad2_i2c_responder.sv
`timescale 1ns/1ps
module tb_ad2_i2c_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic [11:0] ch0_data = 12'h000;
    logic [11:0] ch1_data = 12'h000;
    logic [11:0] ch2_data = 12'h000;
    logic [11:0] ch3_data = 12'h000;
    logic [7:0]  cfg;
    logic        cfg_wr;
    logic [1:0]  rd_ch;
    logic        rd_strobe;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    int       strobe_cnt = 0;
    int       cfg_wr_cnt = 0;
    int       oe_cnt     = 0;
    logic [1:0] strobe_log [16];

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    ad2_i2c_responder dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .ch0_data (ch0_data),
        .ch1_data (ch1_data),
        .ch2_data (ch2_data),
        .ch3_data (ch3_data),
        .cfg      (cfg),
        .cfg_wr   (cfg_wr),
        .rd_ch    (rd_ch),
        .rd_strobe(rd_strobe),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rd_strobe) begin
            strobe_log[strobe_cnt % 16] = rd_ch;
            strobe_cnt = strobe_cnt + 1;
        end
        if (cfg_wr) cfg_wr_cnt = cfg_wr_cnt + 1;
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_q();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b = sda_bus;  wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        read_bit(r);
        ack = ~r;
        $display("  write 0x%02h ack=%0d", b, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            read_bit(r);
            d[i] = r;
        end
        send_bit(~m_ack);
        $display("  read 0x%02h master_ack=%0d", d, m_ack);
    endtask

    task automatic test_reset();
        n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL reset_sda_oe: got %0h expected 0", sda_oe); end
        n_cmp++; if (cfg !== 8'h10) begin n_bad++; $display("FAIL reset_cfg: got %0h expected 10", cfg); end
        n_cmp++; if (cfg_wr !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_wr: got %0h expected 0", cfg_wr); end
        n_cmp++; if (rd_ch !== 2'd0) begin n_bad++; $display("FAIL reset_rd_ch: got %0h expected 0", rd_ch); end
        n_cmp++; if (rd_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_rd_strobe: got %0h expected 0", rd_strobe); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        $display("reset state checked");
    endtask

    task automatic test_write();
        logic a;
        int   w0;
        w0 = cfg_wr_cnt;
        i2c_start();
        write_byte(8'h50, a);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL wr_addr_ack: got %0h expected 1", a); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %0h expected 1", busy); end
        write_byte(8'h30, a);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL wr_data_ack: got %0h expected 1", a); end
        i2c_stop();
        n_cmp++; if (cfg !== 8'h30) begin n_bad++; $display("FAIL wr_cfg: got %0h expected 30", cfg); end
        n_cmp++; if (cfg_wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL wr_cfg_wr_pulses: got %0d expected 1", cfg_wr_cnt - w0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_after_stop: got %0h expected 0", busy); end
        $display("write transaction cfg=0x30 done");
    endtask

    task automatic test_read();
        logic       a;
        logic [7:0] d;
        logic [7:0] exp_rd [6];
        logic [1:0] exp_ch [3];
        int         s0;
        exp_rd = '{8'h0A, 8'hBC, 8'h11, 8'h23, 8'h0A, 8'hBC};
        exp_ch = '{2'd0, 2'd1, 2'd0};
        ch0_data = 12'hABC;
        ch1_data = 12'h123;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h51, a);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL rd_addr_ack: got %0h expected 1", a); end
        for (int i = 0; i < 6; i++) begin
            read_byte(i != 5, d);
            n_cmp++; if (d !== exp_rd[i]) begin n_bad++; $display("FAIL rd_byte%0d: got %02h expected %02h", i, d, exp_rd[i]); end
        end
        n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rd_release: got %0h expected 0", sda_oe); end
        i2c_stop();
        n_cmp++; if (strobe_cnt - s0 !== 3) begin n_bad++; $display("FAIL rd_strobes: got %0d expected 3", strobe_cnt - s0); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (strobe_log[(s0 + k) % 16] !== exp_ch[k]) begin
                n_bad++;
                $display("FAIL rd_ch_seq%0d: got %0d expected %0d", k, strobe_log[(s0 + k) % 16], exp_ch[k]);
            end
        end
        $display("read transaction of 6 bytes done");
    endtask

    task automatic test_bad_addr();
        logic a;
        int   o0;
        o0 = oe_cnt;
        i2c_start();
        write_byte(8'h52, a);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL bad_addr_ack: got %0h expected 0", a); end
        write_byte(8'h10, a);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_addr_busy: got %0h expected 0", busy); end
        i2c_stop();
        n_cmp++; if (oe_cnt !== o0) begin n_bad++; $display("FAIL bad_addr_sda_driven: got %0d cycles expected 0", oe_cnt - o0); end
        n_cmp++; if (cfg !== 8'h30) begin n_bad++; $display("FAIL bad_addr_cfg: got %0h expected 30", cfg); end
        i2c_start();
        write_byte(8'h50, a);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL bad_addr_recover_ack: got %0h expected 1", a); end
        i2c_stop();
        $display("mismatched address 0x29 frame done");
    endtask

    task automatic test_rep_start();
        logic a;
        int   w0;
        w0 = cfg_wr_cnt;
        i2c_start();
        write_byte(8'h50, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_start();
        write_byte(8'h50, a);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL rep_start_ack: got %0h expected 1", a); end
        i2c_stop();
        n_cmp++; if (cfg !== 8'h30) begin n_bad++; $display("FAIL rep_start_cfg: got %0h expected 30", cfg); end
        n_cmp++; if (cfg_wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL rep_start_cfg_wr: got %0d expected 0", cfg_wr_cnt - w0); end
        $display("repeated start mid write byte done");
    endtask

    task automatic test_snapshot();
        logic       a;
        logic [7:0] d;
        i2c_start();
        write_byte(8'h50, a);
        write_byte(8'h10, a);
        i2c_stop();
        ch0_data = 12'hABC;
        i2c_start();
        write_byte(8'h51, a);
        read_byte(1'b1, d);
        n_cmp++; if (d !== 8'h0A) begin n_bad++; $display("FAIL snap_hi: got %02h expected 0a", d); end
        ch0_data = 12'h456;
        read_byte(1'b0, d);
        n_cmp++; if (d !== 8'hBC) begin n_bad++; $display("FAIL snap_lo: got %02h expected bc", d); end
        i2c_stop();
        $display("snapshot read done");
    endtask

    task automatic test_reset_mid();
        logic a;
        i2c_start();
        write_byte(8'h50, a);
        write_byte(8'h20, a);
        i2c_stop();
        ch1_data = 12'h000;
        i2c_start();
        write_byte(8'h51, a);
        n_cmp++; if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL mid_driving: got %0h expected 1", sda_oe); end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sda_oe: got %0h expected 0", sda_oe); end
        n_cmp++; if (cfg !== 8'h10) begin n_bad++; $display("FAIL mid_rst_cfg: got %0h expected 10", cfg); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %0h expected 0", busy); end
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_q();
        $display("reset during driven data bit done");
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_q();
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_rep_start();
        test_snapshot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
